// File: rtl/div_execute_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One op in flight; 32 iteration cycles, or a direct hop to DONE for divide-by-zero and signed overflow.
module div_execute_unit #(
   parameter int unsigned PHY_REG_ID_WIDTH = 6,
   parameter int unsigned ROB_ID_WIDTH     = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        issue_valid,
   output logic                        issue_ready,
   input  logic [1:0]                  issue_op,
   input  logic [31:0]                 issue_rs1_value,
   input  logic [31:0]                 issue_rs2_value,
   input  logic                        issue_rd_enable,
   input  logic [PHY_REG_ID_WIDTH-1:0] issue_rd_phy,
   input  logic [ROB_ID_WIDTH-1:0]     issue_rob_id,
   output logic                        feedback_enable,
   output logic [PHY_REG_ID_WIDTH-1:0] feedback_phy_id,
   output logic [31:0]                 feedback_value,
   output logic                        done_valid,
   output logic [ROB_ID_WIDTH-1:0]     done_rob_id,
   output logic                        busy
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 6;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [XLEN-1:0]             dq_q, dq_d;        // dividend bits shift out, quotient bits shift in
   logic [XLEN-1:0]             rem_q, rem_d;
   logic [XLEN-1:0]             divisor_q, divisor_d;
   logic                        qsign_q, qsign_d;
   logic                        rsign_q, rsign_d;
   logic                        rem_sel_q, rem_sel_d;
   logic                        rd_en_q, rd_en_d;
   logic [PHY_REG_ID_WIDTH-1:0] rd_phy_q, rd_phy_d;
   logic [ROB_ID_WIDTH-1:0]     rob_q, rob_d;

   logic            accept, signed_op, div_zero, ovf;
   logic [XLEN-1:0] rs1_mag, rs2_mag;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] quo_fix, rem_fix;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dq_d      = dq_q;
      rem_d     = rem_q;
      divisor_d = divisor_q;
      qsign_d   = qsign_q;
      rsign_d   = rsign_q;
      rem_sel_d = rem_sel_q;
      rd_en_d   = rd_en_q;
      rd_phy_d  = rd_phy_q;
      rob_d     = rob_q;

      accept    = issue_valid && (state_q == S_IDLE) && !flush;
      signed_op = !issue_op[0];
      rs1_mag   = (signed_op && issue_rs1_value[31]) ? XLEN'(-issue_rs1_value) : issue_rs1_value;
      rs2_mag   = (signed_op && issue_rs2_value[31]) ? XLEN'(-issue_rs2_value) : issue_rs2_value;
      div_zero  = (issue_rs2_value == '0);
      ovf       = signed_op && (issue_rs1_value == 32'h8000_0000) && (issue_rs2_value == '1);
      shifted   = {rem_q, dq_q[XLEN-1]};

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               rem_sel_d = issue_op[1];
               rd_en_d   = issue_rd_enable;
               rd_phy_d  = issue_rd_phy;
               rob_d     = issue_rob_id;
               divisor_d = rs2_mag;
               cnt_d     = '0;
               // Special results are loaded pre-signed, so sign correction is disabled for them
               if (div_zero) begin
                  dq_d    = '1;
                  rem_d   = issue_rs1_value;
                  qsign_d = 1'b0;
                  rsign_d = 1'b0;
                  state_d = S_DONE;
               end else if (ovf) begin
                  dq_d    = 32'h8000_0000;
                  rem_d   = '0;
                  qsign_d = 1'b0;
                  rsign_d = 1'b0;
                  state_d = S_DONE;
               end else begin
                  dq_d    = rs1_mag;
                  rem_d   = '0;
                  qsign_d = signed_op && (issue_rs1_value[31] ^ issue_rs2_value[31]);
                  rsign_d = signed_op && issue_rs1_value[31];
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (shifted >= {1'b0, divisor_q}) begin
               rem_d = XLEN'(shifted - {1'b0, divisor_q});
               dq_d  = {dq_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = shifted[XLEN-1:0];
               dq_d  = {dq_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(31)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         dq_q      <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         qsign_q   <= 1'b0;
         rsign_q   <= 1'b0;
         rem_sel_q <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_phy_q  <= '0;
         rob_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dq_q      <= dq_d;
         rem_q     <= rem_d;
         divisor_q <= divisor_d;
         qsign_q   <= qsign_d;
         rsign_q   <= rsign_d;
         rem_sel_q <= rem_sel_d;
         rd_en_q   <= rd_en_d;
         rd_phy_q  <= rd_phy_d;
         rob_q     <= rob_d;
      end
   end

   // Outputs derive from registered state only
   always_comb begin
      quo_fix         = qsign_q ? XLEN'(-dq_q) : dq_q;
      rem_fix         = rsign_q ? XLEN'(-rem_q) : rem_q;
      feedback_value  = rem_sel_q ? rem_fix : quo_fix;
      feedback_phy_id = rd_phy_q;
      done_rob_id     = rob_q;
      done_valid      = (state_q == S_DONE);
      feedback_enable = (state_q == S_DONE) && rd_en_q;
      issue_ready     = (state_q == S_IDLE);
      busy            = (state_q != S_IDLE);
   end
endmodule

// File: tb/tb_div_execute_unit.sv
// Scoreboard bench for div_execute_unit: driver pushes model results, negedge monitor pops and compares.
module tb_div_execute_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        issue_valid;
   logic        issue_ready;
   logic [1:0]  issue_op;
   logic [31:0] issue_rs1_value;
   logic [31:0] issue_rs2_value;
   logic        issue_rd_enable;
   logic [5:0]  issue_rd_phy;
   logic [4:0]  issue_rob_id;
   logic        feedback_enable;
   logic [5:0]  feedback_phy_id;
   logic [31:0] feedback_value;
   logic        done_valid;
   logic [4:0]  done_rob_id;
   logic        busy;

   typedef struct {
      logic        fe;
      logic [5:0]  phy;
      logic [31:0] value;
      logic [4:0]  rob;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   div_execute_unit #(.PHY_REG_ID_WIDTH(6), .ROB_ID_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_rs1_value(issue_rs1_value), .issue_rs2_value(issue_rs2_value),
      .issue_rd_enable(issue_rd_enable), .issue_rd_phy(issue_rd_phy), .issue_rob_id(issue_rob_id),
      .feedback_enable(feedback_enable), .feedback_phy_id(feedback_phy_id),
      .feedback_value(feedback_value), .done_valid(done_valid), .done_rob_id(done_rob_id),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // RISC-V M-extension semantics from plain arithmetic
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
         sa = $signed(a);
         sb = $signed(b);
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   task automatic do_issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic rd_en, input logic [5:0] phy, input logic [4:0] rob, input bit push);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      while (!issue_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!issue_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_wait: issue_ready stuck low (cycle %0d)", cyc);
      end
      issue_valid     = 1'b1;
      issue_op        = op;
      issue_rs1_value = a;
      issue_rs2_value = b;
      issue_rd_enable = rd_en;
      issue_rd_phy    = phy;
      issue_rob_id    = rob;
      if (push) begin
         e.fe    = rd_en;
         e.phy   = phy;
         e.value = ref_result(op, a, b);
         e.rob   = rob;
         e.cyc   = cyc + (is_special(op, a, b) ? 1 : 33);
         exp_q.push_back(e);
      end
      @(negedge clk);
      issue_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask

   // Monitor: compares every DONE pulse against the scoreboard head
   bit ready_next = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (ready_next) chk("ready_after_done", 32'(issue_ready), 32'd1);
      ready_next = 1'b0;
      if (feedback_enable && !done_valid) begin
         checks++;
         errors++;
         $display("FAIL stray_feedback: feedback_enable=1 without done_valid (cycle %0d)", cyc);
      end
      if (done_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: rob %h value %h (cycle %0d)", done_rob_id, feedback_value, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("feedback_enable", 32'(feedback_enable), 32'(e.fe));
            chk("feedback_phy_id", 32'(feedback_phy_id), 32'(e.phy));
            chk("feedback_value",  feedback_value,       e.value);
            chk("done_rob_id",     32'(done_rob_id),     32'(e.rob));
            chk("done_latency",    32'(cyc),             32'(e.cyc));
            chk("ready_in_done",   32'(issue_ready),     32'd0);
            chk("busy_in_done",    32'(busy),            32'd1);
            ready_next = 1'b1;
         end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL done_timeout: rob %h expected at cycle %0d, none by %0d", e.rob, e.cyc, cyc);
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(issue_ready),     32'd1);
      chk({tag, "_busy"},  32'(busy),            32'd0);
      chk({tag, "_fe"},    32'(feedback_enable), 32'd0);
      chk({tag, "_dv"},    32'(done_valid),      32'd0);
      chk({tag, "_phy"},   32'(feedback_phy_id), 32'd0);
      chk({tag, "_value"}, feedback_value,       32'd0);
      chk({tag, "_rob"},   32'(done_rob_id),     32'd0);
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_op = '0;
      issue_rs1_value = '0; issue_rs2_value = '0; issue_rd_enable = 1'b0;
      issue_rd_phy = '0; issue_rob_id = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b1;

      // Directed cases
      do_issue(2'b00, 32'd100, 32'd7, 1'b1, 6'd12, 5'd3, 1'b1);
      do_issue(2'b10, 32'hFFFF_FF9C, 32'd7, 1'b1, 6'd1, 5'd4, 1'b1);
      do_issue(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1, 6'd2, 5'd5, 1'b1);
      do_issue(2'b11, 32'hFFFF_FFFF, 32'd16, 1'b1, 6'd3, 5'd6, 1'b1);
      do_issue(2'b01, 32'd5, 32'd0, 1'b1, 6'd4, 5'd7, 1'b1);
      do_issue(2'b10, 32'd5, 32'd0, 1'b1, 6'd5, 5'd8, 1'b1);
      do_issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 6'd6, 5'd9, 1'b1);
      do_issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 6'd7, 5'd10, 1'b1);
      do_issue(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, 6'd8, 5'd11, 1'b1);
      wait_drain();

      // Flush mid-CALC: no DONE; the unit is free next cycle
      do_issue(2'b00, 32'd1000, 32'd3, 1'b1, 6'd9, 5'd12, 1'b0);
      repeat (8) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("ready_after_flush", 32'(issue_ready), 32'd1);
      do_issue(2'b00, 32'd9, 32'd3, 1'b1, 6'd10, 5'd13, 1'b1);
      wait_drain();

      // issue_valid with flush held must not accept
      @(negedge clk);
      issue_valid = 1'b1; flush = 1'b1;
      issue_op = 2'b01; issue_rs1_value = 32'd50; issue_rs2_value = 32'd5;
      @(negedge clk);
      chk("no_accept_under_flush", 32'(busy), 32'd0);
      issue_valid = 1'b0; flush = 1'b0;

      // Reset mid-operation
      do_issue(2'b01, 32'd77, 32'd5, 1'b1, 6'd33, 5'd21, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midop_reset");
      rst = 1'b1;
      repeat (40) @(negedge clk);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         int          ra, rb;
         ra = $urandom_range(0, 9);
         rb = $urandom_range(0, 9);
         a = (ra == 0) ? 32'h8000_0000 : (ra == 1) ? 32'($urandom_range(0, 300)) : $urandom;
         b = (rb == 0) ? 32'h0 : (rb == 1) ? 32'hFFFF_FFFF :
             (rb == 2) ? 32'($urandom_range(1, 15)) : $urandom;
         do_issue(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)), 1'b1);
      end
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/div_execute_unit.md
# div_execute_unit

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU group. It sits in the execute stage between the div issue port and the execute-feedback aggregation. It accepts one operation at a time and computes it over 32 iteration cycles, or 1 cycle for the special cases. It then drives a one-cycle feedback channel (physical-register wakeup and value) that feeds the div slot of the execute-feedback pack, plus a completion report for the ROB.

## Interface
- PHY_REG_ID_WIDTH, 6, physical register id width
- ROB_ID_WIDTH, 5, ROB entry id width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush; abandons any in-flight op
- issue_valid  in  1  operation offered
- issue_ready  out  1  unit can accept; high only in IDLE
- issue_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- issue_rs1_value  in  32  dividend
- issue_rs2_value  in  32  divisor
- issue_rd_enable  in  1  instruction writes rd
- issue_rd_phy  in  PHY_REG_ID_WIDTH  destination physical register
- issue_rob_id  in  ROB_ID_WIDTH  ROB entry
- feedback_enable  out  1  broadcast valid; equals latched rd_enable, qualified by DONE
- feedback_phy_id  out  PHY_REG_ID_WIDTH  destination physical register
- feedback_value  out  32  result
- done_valid  out  1  completion report to ROB, one cycle
- done_rob_id  out  ROB_ID_WIDTH  completing ROB entry
- busy  out  1  high in CALC or DONE

## Operation
- States: IDLE, CALC, DONE.
- Accept: issue_valid && issue_ready && !flush.
  - Latch op, rd_enable, rd_phy, rob_id.
  - Latch operand magnitudes: abs for DIV/REM, raw for DIVU/REMU.
  - Latch quotient sign = sign(rs1) ^ sign(rs2) and remainder sign = sign(rs1). Both are signed ops only.
- Special cases, detected at accept: IDLE -> DONE directly, with no CALC.
  - Divisor == 0: quotient = 0xFFFFFFFF; remainder = rs1 unmodified. Applies to all 4 ops.
  - Signed overflow, DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Normal case: IDLE -> CALC.
  - 6-bit iteration counter cleared at accept.
- CALC: restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder: shifted = {rem[31:0], dividend_msb}.
  - If shifted >= {1'b0, divisor}: subtract and set the quotient bit.
  - After iteration 31 (counter == 31): -> DONE.
- DONE:
  - Apply sign correction.
    - Quotient: negated if quotient sign is set.
    - Remainder: negated if remainder sign is set.
    - Result is the quotient for DIV/DIVU and the remainder for REM/REMU.
  - Outputs valid for exactly this one cycle.
  - Next state is IDLE unconditionally.
- feedback_phy_id, feedback_value and done_rob_id are driven from latched/datapath state in every state. They are meaningful only when done_valid=1.
- rd_enable=0: full execution; done_valid=1; feedback_enable=0.
- flush:
  - In IDLE or CALC: next state IDLE, no DONE is ever produced.
  - In DONE: outputs remain as driven that cycle; the consumer squashes them. Next state IDLE.
  - flush takes priority over accept.
- Reset: state IDLE, counter 0, all latched fields 0, so every output is 0 except issue_ready.
  - Reset mid-operation discards the op; no feedback is produced.

## Timing
- Accept edge = E. Normal op: CALC in cycles E+1..E+32, DONE in cycle E+33. Latency is 33 cycles.
- Special case: DONE in cycle E+1. Latency is 1 cycle.
- issue_ready is low from E+1 through the DONE cycle.
  - It is high again in the cycle after DONE, so the earliest next accept edge is DONE+1.
  - Throughput is 1 op per 34 cycles (normal) or per 2 cycles (special).
- No back-pressure on feedback/done: the downstream consumer always sinks them.
- Outputs are registered state or state-derived combinational logic. There are no combinational paths from issue_* to feedback_* or done_*.
- Reset values:
  - issue_ready=1 (rst deasserted, state IDLE).
  - busy=0, feedback_enable=0, done_valid=0.
  - feedback_phy_id=0, feedback_value=0, done_rob_id=0.

## Test plan
- DIV 100/7, rd_enable=1, phy 12, rob 3 -> 33 cycles after accept, one-cycle pulse: feedback_enable=1, feedback_phy_id=12, feedback_value=14, done_valid=1, done_rob_id=3. issue_ready is high again the next cycle.
- REM: rs1=0xFFFFFF9C (-100), rs2=7 -> feedback_value=0xFFFFFFFE (-2). DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. REMU 0xFFFFFFFF/16 -> 0xF.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each in cycle E+1 with no CALC cycles.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at E+1. REM with the same operands -> 0.
- Flush at cycle E+10 -> no done_valid or feedback_enable pulse ever appears for that op. issue_ready=1 the next cycle, and a new DIV 9/3 then returns 3 after 33 cycles.
- rst low at E+5 -> all outputs at reset values the next cycle and no stale pulse. Also: issue_valid held high with flush=1 -> no accept.
